// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_n_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// One-bit full adder built from two half-adder stages; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g_ab;
  logic g_pc;

  // First half adder combines the operand bits, second folds in the carry.
  assign p    = a ^ b;
  assign g_ab = a & b;
  assign s    = p ^ cin;
  assign g_pc = p & cin;
  assign cout = g_ab | g_pc;

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per cycle, LSB first.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] shifted;
  logic             fa_s;
  logic             fa_cout;

  // Subtraction reuses the adder with the latched B inverted and a forced carry-in of 1.
  fa_cell u_fa (
    .a   (a_reg[0]),
    .b   (b_reg[0] ^ sub_reg),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  assign shifted = {fa_s, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      sub_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_sh  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          carry  <= fa_cout;
          res_sh <= shifted[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          // On the MSB cycle, carry still holds the carry into the MSB, which gives signed overflow.
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= shifted;
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and random self-checking bench for serial_adder_n at WIDTH 8 and 16.
module tb_serial_adder_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one 8-bit operation and returns the number of rising edges until done is seen.
  task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                               input logic c, output int edges);
    @(negedge clk);
    start8 = 1'b1; sub8 = s; a8 = av; b8 = bv; cin8 = c;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      start8 = 1'b0;
    end while (!done8 && edges < 40);
  endtask

  task automatic applyStimulus16(input logic s, input logic [15:0] av, input logic [15:0] bv,
                                 input logic c, output int edges);
    @(negedge clk);
    start16 = 1'b1; sub16 = s; a16 = av; b16 = bv; cin16 = c;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      start16 = 1'b0;
    end while (!done16 && edges < 60);
  endtask

  initial begin
    int          edges;
    int          done_seen;
    logic        rs, rc;
    logic [15:0] ra, rb, bb;
    logic [16:0] full;
    logic        exp_ovf;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy8), 64'd0);
    checkOutput("reset_done", 64'(done8), 64'd0);
    checkOutput("reset_sum", 64'(sum8), 64'd0);
    checkOutput("reset_cout_ovf", 64'({cout8, ovf8}), 64'd0);
    checkOutput("reset_sum16", 64'({busy16, done16, sum16}), 64'd0);
    rst = 1'b0;

    // Add with signed overflow, then check the idle cycle after done.
    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, edges);
    checkOutput("add1_latency", 64'(edges), 64'd9);
    checkOutput("add1_sum", 64'(sum8), 64'h96);
    checkOutput("add1_cout", 64'(cout8), 64'd0);
    checkOutput("add1_ovf", 64'(ovf8), 64'd1);
    checkOutput("add1_busy_in_done", 64'(busy8), 64'd0);
    @(negedge clk);
    checkOutput("add1_done_one_cycle", 64'(done8), 64'd0);
    checkOutput("add1_sum_held", 64'(sum8), 64'h96);

    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b1, edges);
    checkOutput("add2_sum", 64'(sum8), 64'h01);
    checkOutput("add2_cout", 64'(cout8), 64'd1);
    checkOutput("add2_ovf", 64'(ovf8), 64'd0);

    applyStimulus(1'b1, 8'h10, 8'h20, 1'b1, edges);
    checkOutput("sub1_latency", 64'(edges), 64'd9);
    checkOutput("sub1_sum", 64'(sum8), 64'hF0);
    checkOutput("sub1_cout", 64'(cout8), 64'd0);
    checkOutput("sub1_ovf", 64'(ovf8), 64'd0);

    // Back-to-back: start pulses with junk during RUN, then held high with a=3,b=4 into DONE.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges < 3) begin
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
      end
      if (edges == 4) begin
        checkOutput("b2b_busy_in_run", 64'(busy8), 64'd1);
        checkOutput("b2b_sum_frozen_in_run", 64'(sum8), 64'hF0);
      end
    end while (!done8 && edges < 40);
    checkOutput("b2b_first_latency", 64'(edges), 64'd9);
    checkOutput("b2b_first_sum", 64'(sum8), 64'h30);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      start8 = 1'b0;
      if (edges == 4) checkOutput("b2b_second_sum_held", 64'(sum8), 64'h30);
    end while (!done8 && edges < 40);
    checkOutput("b2b_second_latency", 64'(edges), 64'd9);
    checkOutput("b2b_second_sum", 64'(sum8), 64'h07);
    checkOutput("b2b_second_cout_ovf", 64'({cout8, ovf8}), 64'd0);

    // Reset while bit 4 is about to be processed discards the partial result.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_run_busy", 64'(busy8), 64'd0);
    checkOutput("rst_run_done", 64'(done8), 64'd0);
    checkOutput("rst_run_sum", 64'(sum8), 64'd0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    checkOutput("rst_run_no_done", 64'(done_seen), 64'd0);

    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, edges);
    checkOutput("post_rst_latency", 64'(edges), 64'd9);
    checkOutput("post_rst_result", 64'({cout8, ovf8, sum8}), 64'({1'b0, 1'b1, 8'h96}));

    // WIDTH=16 random add/sub against an arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom);
      rc = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + 17'(rs ? 1'b1 : rc);
      exp_ovf = (ra[15] == bb[15]) && (full[15] != ra[15]);
      applyStimulus16(rs, ra, rb, rc, edges);
      checkOutput("rand16_cout_sum", 64'({cout16, sum16}), 64'(full));
      checkOutput("rand16_ovf", 64'(ovf16), 64'(exp_ovf));
      if (i == 0) checkOutput("rand16_latency", 64'(edges), 64'd17);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
